// File: rtl/neuron_input_loader.sv
// ---------------------------------------------------------------------------
// neuron_input_loader
//
// Purpose:
//   Upstream feeder for the parallel dot-product neuron. A serial valid/ready
//   stream of (activation, weight) beats is packed lane by lane into
//   INPUT_WIDTH-wide parallel vectors. Each vector is launched with a single
//   one-cycle valid pulse. The stream is then stalled until the neuron reports
//   completion, so only one vector is ever in flight.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   s_valid      stream beat valid
//   s_ready      loader can accept a beat (only while filling)
//   s_act        signed activation of the current beat
//   s_wgt        signed weight of the current beat
//   s_bias       signed bias, taken from beat 0 of a vector only
//   s_last       final beat of a vector (may arrive early for short vectors)
//   a_out        packed activations, lane k = beat k
//   w_out        packed weights, lane k = beat k
//   bias_out     bias for the vector being presented
//   valid_out    one-cycle launch pulse to the neuron
//   neuron_done  completion strobe from the neuron
//   busy         high while a vector is launching or in flight
//   vec_count    vectors issued since reset, wraps
//   err_no_last  sticky: a vector filled every lane without s_last
// ---------------------------------------------------------------------------
module neuron_input_loader #(
  parameter int INPUT_WIDTH = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   s_valid,
  output logic                                   s_ready,
  input  logic signed [DATA_WIDTH-1:0]           s_act,
  input  logic signed [DATA_WIDTH-1:0]           s_wgt,
  input  logic signed [DATA_WIDTH-1:0]           s_bias,
  input  logic                                   s_last,
  output logic [INPUT_WIDTH-1:0][DATA_WIDTH-1:0] a_out,
  output logic [INPUT_WIDTH-1:0][DATA_WIDTH-1:0] w_out,
  output logic signed [DATA_WIDTH-1:0]           bias_out,
  output logic                                   valid_out,
  input  logic                                   neuron_done,
  output logic                                   busy,
  output logic [CNT_WIDTH-1:0]                   vec_count,
  output logic                                   err_no_last
);

  // Beat index is just wide enough to address every lane.
  localparam int IDX_W = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [INPUT_WIDTH-1:0][DATA_WIDTH-1:0] a_q, a_d;
  logic [INPUT_WIDTH-1:0][DATA_WIDTH-1:0] w_q, w_d;
  logic [DATA_WIDTH-1:0]                  bias_q, bias_d;
  logic [IDX_W-1:0]                       idx_q, idx_d;
  logic [CNT_WIDTH-1:0]                   cnt_q, cnt_d;
  logic                                   err_q, err_d;

  logic beat_accept;
  logic at_last_lane;
  logic fill_done;

  // A beat is only consumed in FILL; s_ready is derived from the state alone,
  // so a beat offered during ISSUE/WAIT simply waits at the source.
  assign beat_accept  = s_valid & s_ready;
  assign at_last_lane = (idx_q == LAST_IDX);
  // Either an explicit s_last or running out of lanes closes the vector.
  assign fill_done    = beat_accept & (s_last | at_last_lane);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. ISSUE always lasts exactly one cycle; a done strobe
  // outside WAIT is not meaningful and is ignored.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: begin
        if (fill_done) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (neuron_done) begin
          state_d = ST_FILL;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Moore outputs: handshake, launch pulse and busy depend on state only.
  // -------------------------------------------------------------------------
  always_comb begin
    s_ready   = 1'b0;
    valid_out = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_FILL: begin
        s_ready = 1'b1;
      end
      ST_ISSUE: begin
        valid_out = 1'b1;
        busy      = 1'b1;
      end
      ST_WAIT: begin
        busy = 1'b1;
      end
      default: begin
        s_ready = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath next-state. Lanes and bias are cleared when the neuron finishes
  // so that a following short vector leaves its unused lanes at zero and
  // contributes nothing to the dot product.
  // -------------------------------------------------------------------------
  always_comb begin
    a_d    = a_q;
    w_d    = w_q;
    bias_d = bias_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    case (state_q)
      ST_FILL: begin
        if (beat_accept) begin
          a_d[idx_q] = s_act;
          w_d[idx_q] = s_wgt;
          if (idx_q == '0) begin
            bias_d = s_bias;
          end
          if (s_last || at_last_lane) begin
            idx_d = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
          // Lanes exhausted without a framing marker: still launch, but flag it.
          if (at_last_lane && !s_last) begin
            err_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
      ST_WAIT: begin
        if (neuron_done) begin
          a_d    = '0;
          w_d    = '0;
          bias_d = '0;
          idx_d  = '0;
        end
      end
      default: begin
        idx_d = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers. Reset discards any partial or in-flight vector.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      w_q    <= '0;
      bias_q <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      w_q    <= w_d;
      bias_q <= bias_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign a_out       = a_q;
  assign w_out       = w_q;
  assign bias_out    = bias_q;
  assign vec_count   = cnt_q;
  assign err_no_last = err_q;

endmodule

// File: tb/tb_neuron_input_loader.sv
// ---------------------------------------------------------------------------
// tb_neuron_input_loader
//
// Purpose:
//   Directed bench for neuron_input_loader. Each launched vector's expected
//   lanes, bias, count and error flag are queued when the vector is built; a
//   separate monitor pops and compares whenever valid_out is seen. A small
//   neuron stub answers each launch with a delayed done strobe.
// ---------------------------------------------------------------------------
module tb_neuron_input_loader;

  localparam int N  = 10;
  localparam int DW = 16;
  localparam int CW = 16;

  typedef struct {
    logic [N-1:0][DW-1:0] a;
    logic [N-1:0][DW-1:0] w;
    logic [DW-1:0]        bias;
    logic [CW-1:0]        cnt;
    logic                 err;
  } expVec_t;

  logic                 clk;
  logic                 rst;
  logic                 s_valid;
  logic                 s_ready;
  logic [DW-1:0]        s_act;
  logic [DW-1:0]        s_wgt;
  logic [DW-1:0]        s_bias;
  logic                 s_last;
  logic [N-1:0][DW-1:0] a_out;
  logic [N-1:0][DW-1:0] w_out;
  logic [DW-1:0]        bias_out;
  logic                 valid_out;
  wire                  neuron_done;
  logic                 busy;
  logic [CW-1:0]        vec_count;
  logic                 err_no_last;

  logic stubDone;
  logic manualDone;
  logic stubEnable;
  int   doneDelay;
  int   countdown;

  expVec_t       expQ[$];
  expVec_t       expCur;
  logic [CW-1:0] expCount;
  logic          expErr;
  logic          prevValid;

  int testsRun;
  int testsFailed;

  assign neuron_done = stubDone | manualDone;

  neuron_input_loader #(
    .INPUT_WIDTH(N),
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_act      (s_act),
    .s_wgt      (s_wgt),
    .s_bias     (s_bias),
    .s_last     (s_last),
    .a_out      (a_out),
    .w_out      (w_out),
    .bias_out   (bias_out),
    .valid_out  (valid_out),
    .neuron_done(neuron_done),
    .busy       (busy),
    .vec_count  (vec_count),
    .err_no_last(err_no_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Neuron stub: answers a launch with a one-cycle done after doneDelay cycles.
  always @(posedge clk) begin
    #1;
    stubDone = 1'b0;
    if (rst) begin
      countdown = 0;
    end else if (countdown > 0) begin
      countdown = countdown - 1;
      if (countdown == 0) stubDone = 1'b1;
    end else if (valid_out && stubEnable) begin
      countdown = doneDelay;
    end
  end

  task automatic checkOutput(input string name, input logic [255:0] actual,
                             input logic [255:0] expected);
    testsRun = testsRun + 1;
    if (actual !== expected) begin
      testsFailed = testsFailed + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: every launch must match the oldest queued expectation.
  always @(negedge clk) begin
    expVec_t e;
    if (valid_out) begin
      if (prevValid) begin
        checkOutput("launchPulseWidth", 256'(valid_out & prevValid), 256'd0);
      end else if (expQ.size() == 0) begin
        checkOutput("unexpectedLaunch", 256'(expQ.size()), 256'd1);
      end else begin
        e = expQ.pop_front();
        checkOutput("launch.a_out", a_out, e.a);
        checkOutput("launch.w_out", w_out, e.w);
        checkOutput("launch.bias_out", bias_out, e.bias);
        checkOutput("launch.vec_count", vec_count, e.cnt);
        checkOutput("launch.err_no_last", err_no_last, e.err);
      end
    end
    prevValid = valid_out;
  end

  // Drive one beat from a negedge and return at the negedge after it is taken.
  task automatic applyStimulus(input logic [DW-1:0] act, input logic [DW-1:0] wgt,
                               input logic [DW-1:0] bias, input logic last);
    int n = 0;
    s_valid = 1'b1;
    s_act   = act;
    s_wgt   = wgt;
    s_bias  = bias;
    s_last  = last;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      checkOutput("beatReadyTimeout", 256'(s_ready), 256'd1);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic clearExpected();
    expCur.a    = '0;
    expCur.w    = '0;
    expCur.bias = '0;
    expCur.cnt  = '0;
    expCur.err  = 1'b0;
  endtask

  task automatic pushExpected(input logic withErr);
    expCur.cnt = expCount;
    expCount   = expCount + CW'(1);
    if (withErr) expErr = 1'b1;
    expCur.err = expErr;
    expQ.push_back(expCur);
  endtask

  // Loader idle in FILL with cleared lanes.
  task automatic checkIdle(input string tag);
    checkOutput({tag, ".s_ready"}, s_ready, 1'b1);
    checkOutput({tag, ".busy"}, busy, 1'b0);
    checkOutput({tag, ".valid_out"}, valid_out, 1'b0);
    checkOutput({tag, ".a_out"}, a_out, 256'd0);
    checkOutput({tag, ".w_out"}, w_out, 256'd0);
    checkOutput({tag, ".bias_out"}, bias_out, 256'd0);
    checkOutput({tag, ".vec_count"}, vec_count, expCount);
    checkOutput({tag, ".err_no_last"}, err_no_last, expErr);
  endtask

  // Called at the negedge of the launch cycle; waits for the stub's done.
  task automatic waitDone(input string tag);
    int   n     = 0;
    logic lowOk = 1'b1;
    checkOutput({tag, ".launchAfterLast"}, valid_out, 1'b1);
    checkOutput({tag, ".busyIssue"}, busy, 1'b1);
    while (!neuron_done && n < 100) begin
      if (s_ready) lowOk = 1'b0;
      @(negedge clk);
      n++;
    end
    checkOutput({tag, ".doneSeen"}, neuron_done, 1'b1);
    checkOutput({tag, ".readyLowInWait"}, lowOk, 1'b1);
    @(negedge clk);
    checkIdle({tag, ".afterDone"});
  endtask

  task automatic doReset(input int cycles);
    rst     = 1'b1;
    s_valid = 1'b0;
    repeat (cycles) @(negedge clk);
    rst      = 1'b0;
    expCount = '0;
    expErr   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst         = 1'b1;
    s_valid     = 1'b0;
    s_act       = '0;
    s_wgt       = '0;
    s_bias      = '0;
    s_last      = 1'b0;
    manualDone  = 1'b0;
    stubDone    = 1'b0;
    stubEnable  = 1'b1;
    doneDelay   = 3;
    countdown   = 0;
    prevValid   = 1'b0;
    expCount    = '0;
    expErr      = 1'b0;
    clearExpected();

    // Reset held for three cycles.
    @(negedge clk);
    doReset(3);
    checkIdle("reset");

    // Full vector: act = k+1, wgt = -(k+1), bias 5, s_last on beat 9.
    clearExpected();
    for (int k = 0; k < N; k++) begin
      expCur.a[k] = DW'(k + 1);
      expCur.w[k] = DW'(-(k + 1));
    end
    expCur.bias = DW'(5);
    pushExpected(1'b0);
    for (int k = 0; k < N; k++) begin
      applyStimulus(DW'(k + 1), DW'(-(k + 1)), (k == 0) ? DW'(5) : DW'(77), k == N - 1);
    end
    waitDone("full");

    // Short vector: three beats, bias only from beat 0.
    clearExpected();
    for (int k = 0; k < 3; k++) begin
      expCur.a[k] = DW'(7);
      expCur.w[k] = DW'(2);
    end
    expCur.bias = DW'(-4);
    pushExpected(1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(DW'(7), DW'(2), (k == 0) ? DW'(-4) : DW'(99), k == 2);
    end
    waitDone("short");

    // Missing last: ten beats without s_last still launch and flag an error.
    clearExpected();
    for (int k = 0; k < N; k++) begin
      expCur.a[k] = DW'(100 + k);
      expCur.w[k] = DW'(k - 5);
    end
    expCur.bias = DW'(-300);
    pushExpected(1'b1);
    for (int k = 0; k < N; k++) begin
      applyStimulus(DW'(100 + k), DW'(k - 5), DW'(-300), 1'b0);
    end
    waitDone("noLast");

    // Spurious done during FILL is ignored; lanes continue where they left off.
    clearExpected();
    for (int k = 0; k < 4; k++) begin
      expCur.a[k] = DW'(-(k + 2));
      expCur.w[k] = DW'(16'h0100 + k);
    end
    expCur.bias = DW'(1234);
    pushExpected(1'b0);
    applyStimulus(DW'(-2), DW'(16'h0100), DW'(1234), 1'b0);
    applyStimulus(DW'(-3), DW'(16'h0101), DW'(0), 1'b0);
    manualDone = 1'b1;
    @(negedge clk);
    manualDone = 1'b0;
    checkOutput("spuriousDone.s_ready", s_ready, 1'b1);
    checkOutput("spuriousDone.busy", busy, 1'b0);
    @(negedge clk);
    applyStimulus(DW'(-4), DW'(16'h0102), DW'(0), 1'b0);
    applyStimulus(DW'(-5), DW'(16'h0103), DW'(0), 1'b1);
    waitDone("spuriousDone");

    // Backpressure: a beat held during WAIT is not consumed.
    stubEnable = 1'b0;
    clearExpected();
    for (int k = 0; k < N; k++) begin
      expCur.a[k] = DW'(16'h1000 + k);
      expCur.w[k] = DW'(k * k);
    end
    expCur.bias = DW'(-1);
    pushExpected(1'b0);
    for (int k = 0; k < N; k++) begin
      applyStimulus(DW'(16'h1000 + k), DW'(k * k), DW'(-1), k == N - 1);
    end
    s_valid = 1'b1;
    s_act   = 16'h7777;
    s_wgt   = 16'h7777;
    s_bias  = 16'h7777;
    repeat (6) @(negedge clk);
    checkOutput("backpressure.s_ready", s_ready, 1'b0);
    checkOutput("backpressure.busy", busy, 1'b1);
    checkOutput("backpressure.a_out", a_out, expCur.a);
    checkOutput("backpressure.w_out", w_out, expCur.w);
    checkOutput("backpressure.bias_out", bias_out, expCur.bias);
    s_valid    = 1'b0;
    manualDone = 1'b1;
    @(negedge clk);
    manualDone = 1'b0;
    checkIdle("backpressure.afterDone");

    // Reset in the middle of FILL discards the partial vector and the error.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(DW'(50 + k), DW'(60 + k), DW'(70), 1'b0);
    end
    doReset(1);
    checkIdle("resetMidFill");

    // Reset during WAIT.
    clearExpected();
    for (int k = 0; k < N; k++) begin
      expCur.a[k] = DW'(3 * k);
      expCur.w[k] = DW'(-2 * k);
    end
    expCur.bias = DW'(8);
    pushExpected(1'b0);
    for (int k = 0; k < N; k++) begin
      applyStimulus(DW'(3 * k), DW'(-2 * k), DW'(8), k == N - 1);
    end
    repeat (2) @(negedge clk);
    checkOutput("preResetWait.vec_count", vec_count, CW'(1));
    doReset(1);
    checkIdle("resetMidWait");

    // Clean vector after reset loads from lane 0 and counts from zero.
    stubEnable = 1'b1;
    clearExpected();
    expCur.a[0] = DW'(11);
    expCur.a[1] = DW'(22);
    expCur.w[0] = DW'(-3);
    expCur.w[1] = DW'(-4);
    expCur.bias = DW'(9);
    pushExpected(1'b0);
    applyStimulus(DW'(11), DW'(-3), DW'(9), 1'b0);
    applyStimulus(DW'(22), DW'(-4), DW'(0), 1'b1);
    waitDone("afterReset");

    checkOutput("allLaunchesSeen", 256'(expQ.size()), 256'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/neuron_input_loader.md
Name: neuron_input_loader

Overview:
- Upstream feeder for the parallel dot-product neuron.
- Accepts a serial valid/ready stream of (activation, weight) pairs plus a per-vector bias.
- Packs the pairs into INPUT_WIDTH-wide parallel vectors and issues each vector to the neuron with a one-cycle valid pulse.
- Stalls the stream until the neuron reports completion (its valid_out), so only one vector is in flight at a time.

Parameters:
- INPUT_WIDTH, 10, number of (activation, weight) pairs per vector; must be ≥2.
- DATA_WIDTH, 16, signed width of activation, weight and bias.
- CNT_WIDTH, 16, width of the issued-vector counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  stream beat valid.
- s_ready  out  1  loader can accept a beat.
- s_act  in  DATA_WIDTH  signed activation for the current beat.
- s_wgt  in  DATA_WIDTH  signed weight for the current beat.
- s_bias  in  DATA_WIDTH  signed bias; sampled only on beat 0 of a vector.
- s_last  in  1  marks the final beat of a vector.
- a_out  out  INPUT_WIDTH x DATA_WIDTH  packed activations to the neuron's a_in.
- w_out  out  INPUT_WIDTH x DATA_WIDTH  packed weights to the neuron's w_in.
- bias_out  out  DATA_WIDTH  bias to the neuron.
- valid_out  out  1  one-cycle launch pulse to the neuron's valid_in.
- neuron_done  in  1  neuron's valid_out.
- busy  out  1  high in ISSUE and WAIT.
- vec_count  out  CNT_WIDTH  number of vectors issued since reset; wraps.
- err_no_last  out  1  sticky: vector filled without s_last on its final beat.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=FILL, beat index idx=0.
  - a_out, w_out, bias_out all 0.
  - valid_out=0, busy=0, vec_count=0, err_no_last=0.
  - rst overrides everything, including mid-FILL and mid-WAIT; partial vectors are discarded.
- State FILL:
  - s_ready=1.
  - A beat is accepted when s_valid & s_ready at a clk edge; it writes a_out[idx]=s_act and w_out[idx]=s_wgt.
  - When idx==0, bias_out=s_bias is also written.
  - If s_last=1 or idx==INPUT_WIDTH-1: go to ISSUE and set idx=0. Otherwise idx increments.
  - Early s_last (idx<INPUT_WIDTH-1) is a legal short vector. Unwritten lanes remain 0 because lanes are cleared on every WAIT→FILL transition.
  - If idx==INPUT_WIDTH-1 and s_last=0: the vector still launches and err_no_last is set. It clears only on rst.
- State ISSUE (exactly one cycle):
  - valid_out=1, s_ready=0, busy=1.
  - Next state is WAIT.
  - valid_out is a Moore output: last beat accepted at edge T → valid_out high for the cycle following T.
  - vec_count increments on leaving ISSUE, wrapping modulo 2^CNT_WIDTH.
- State WAIT:
  - s_ready=0, busy=1.
  - a_out, w_out and bias_out are held stable.
  - On neuron_done=1 at an edge: go to FILL, clear all a_out/w_out lanes and bias_out to 0, idx=0.
  - s_ready is high the cycle after neuron_done is sampled.
- neuron_done while in FILL or ISSUE is ignored; no state change, no error.
- s_valid while s_ready=0: the beat is not consumed. The upstream source must hold it until s_ready=1.
- Throughput per vector is N beats + 1 (ISSUE) + neuron latency + 1.
- No arithmetic is performed; values pass through bit-exact, signed.
- Lane order: beat k maps to index k.

Test Plan:
- Reset: hold rst=1 for 3 cycles → all outputs 0, s_ready=1 after release, busy=0, vec_count=0.
- Full vector: stream 10 beats, act=k+1, wgt=-(k+1) for k=0..9, bias=5 on beat 0, s_last on beat 9; stub neuron_done 3 cycles after valid_out.
  - a_out={1..10}, w_out={-1..-10}, bias_out=5.
  - valid_out high exactly 1 cycle, the cycle after beat 9.
  - s_ready low until the cycle after neuron_done; vec_count=1; err_no_last=0.
- Short vector: after a prior full vector, send 3 beats (act=7, wgt=2, bias=-4) with s_last on beat 2 → lanes 0..2 = 7/2, lanes 3..9 = 0, bias_out=-4, single valid_out pulse.
- Missing last: 10 beats with s_last=0 throughout → launch after beat 9, err_no_last=1 and remains 1 through later clean vectors until rst.
- Backpressure and spurious done:
  - Hold s_valid=1 during WAIT → no beats consumed, outputs stable.
  - Pulse neuron_done during FILL → ignored, idx unchanged.
- Reset mid-operation: assert rst after beat 4 of a vector and again during WAIT → state returns to FILL, outputs 0, the next vector loads cleanly from lane 0, and vec_count restarts at 0.
